ecc_err_logger: RTL and testbench

- Sits directly downstream of the SECDED decoder on the read path.
- Consumes the decoder's per-beat valid and single/double error flags, plus the address tag of that read beat.
- Maintains saturating correctable (CE) and uncorrectable (UE) error counters and buffers error records in a small FIFO for firmware/sideband drain.
- Raises a sticky interrupt when a UE is seen or the CE count reaches a programmable threshold.

---
 rtl/ecc_err_logger.sv | 121 ++++++++++++
 tb/tb_ecc_err_logger.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/ecc_err_logger.sv
// rtl/ecc_err_logger.sv - SECDED error counters, error-record FIFO and sticky interrupt
module ecc_err_logger #(
  parameter int ADDR_WIDTH = 32,
  parameter int CNT_WIDTH  = 16,
  parameter int LOG_DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  dec_valid,
  input  logic                  single_err,
  input  logic                  double_err,
  input  logic [ADDR_WIDTH-1:0] dec_addr,
  input  logic                  clear,
  input  logic [CNT_WIDTH-1:0]  ce_threshold,
  output logic                  log_valid,
  input  logic                  log_ready,
  output logic                  log_type,
  output logic [ADDR_WIDTH-1:0] log_addr,
  output logic [CNT_WIDTH-1:0]  ce_count,
  output logic [CNT_WIDTH-1:0]  ue_count,
  output logic                  log_overflow,
  output logic                  irq
);

  localparam int PW = $clog2(LOG_DEPTH);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  // Record layout: {type, addr}, type 1 = UE
  logic [ADDR_WIDTH:0] mem [LOG_DEPTH];
  logic [PW:0]         wr_ptr;
  logic [PW:0]         rd_ptr;
  logic                empty;
  logic                full;
  logic                evt;
  logic                ce_inc;
  logic                ue_inc;
  logic                pop;
  logic                we;
  logic [PW-1:0]       wr_idx;
  logic [ADDR_WIDTH:0] head;
  logic                ue_seen;

  assign empty  = (wr_ptr == rd_ptr);
  assign full   = (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]) && (wr_ptr[PW] != rd_ptr[PW]);
  assign evt    = dec_valid & (single_err | double_err);
  assign ue_inc = evt & double_err;
  assign ce_inc = evt & ~double_err;
  // Clear wins over a pop; a same-cycle event lands in the freshly emptied FIFO
  assign pop    = ~empty & log_ready & ~clear;
  assign we     = evt & (clear | ~full | pop);
  assign wr_idx = clear ? '0 : wr_ptr[PW-1:0];
  assign head   = mem[rd_ptr[PW-1:0]];

  // Head presentation is gated so outputs read zero whenever nothing is queued
  assign log_valid = ~empty;
  assign log_type  = log_valid & head[ADDR_WIDTH];
  assign log_addr  = log_valid ? head[ADDR_WIDTH-1:0] : '0;

  // FIFO pointers: clear restarts at slot 0, holding the same-cycle record if any
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= {{PW{1'b0}}, evt};
    end else begin
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (we)  wr_ptr <= wr_ptr + 1'b1;
    end
  end

  // Record storage; contents need no reset since the head is gated by log_valid
  always_ff @(posedge clk) begin
    if (we) mem[wr_idx] <= {double_err, dec_addr};
  end

  // Sticky overflow when a record is dropped for lack of space
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      log_overflow <= 1'b0;
    end else if (clear) begin
      log_overflow <= 1'b0;
    end else if (evt && full && !pop) begin
      log_overflow <= 1'b1;
    end
  end

  // Saturating error counters; a same-cycle event is counted on top of a clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ce_count <= '0;
      ue_count <= '0;
    end else if (clear) begin
      ce_count <= ce_inc ? CNT_ONE : '0;
      ue_count <= ue_inc ? CNT_ONE : '0;
    end else begin
      if (ce_inc && ce_count != CNT_MAX) ce_count <= ce_count + CNT_ONE;
      if (ue_inc && ue_count != CNT_MAX) ue_count <= ue_count + CNT_ONE;
    end
  end

  // Remembers that a UE was counted at the last edge so irq follows one cycle later
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ue_seen <= 1'b0;
    else     ue_seen <= ue_inc;
  end

  // Sticky interrupt evaluated from the registered counter state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq <= 1'b0;
    end else if (clear) begin
      irq <= 1'b0;
    end else if (ue_seen || (ce_threshold != '0 && ce_count >= ce_threshold)) begin
      irq <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ecc_err_logger.sv
// tb/tb_ecc_err_logger.sv - randomized scoreboard bench for ecc_err_logger
module tb_ecc_err_logger;

  localparam int AW    = 32;
  localparam int CW    = 4;
  localparam int DEPTH = 4;
  localparam int MAX   = 15;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          dec_valid = 1'b0;
  logic          single_err = 1'b0;
  logic          double_err = 1'b0;
  logic [AW-1:0] dec_addr = '0;
  logic          clear = 1'b0;
  logic [CW-1:0] ce_threshold = '0;
  logic          log_valid;
  logic          log_ready = 1'b0;
  logic          log_type;
  logic [AW-1:0] log_addr;
  logic [CW-1:0] ce_count;
  logic [CW-1:0] ue_count;
  logic          log_overflow;
  logic          irq;

  ecc_err_logger #(.ADDR_WIDTH(AW), .CNT_WIDTH(CW), .LOG_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .dec_valid(dec_valid), .single_err(single_err),
    .double_err(double_err), .dec_addr(dec_addr), .clear(clear),
    .ce_threshold(ce_threshold), .log_valid(log_valid), .log_ready(log_ready),
    .log_type(log_type), .log_addr(log_addr), .ce_count(ce_count),
    .ue_count(ue_count), .log_overflow(log_overflow), .irq(irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit            t;
    logic [AW-1:0] a;
  } rec_t;

  rec_t sb[$];
  int   m_ce, m_ue, m_occ;
  bit   m_ovf, m_irq, m_ue_pend;
  int   checks = 0;
  int   passes = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    m_ce = 0; m_ue = 0; m_occ = 0;
    m_ovf = 0; m_irq = 0; m_ue_pend = 0;
    sb.delete();
  endtask

  // Monitor: whenever a record is presented, it must match the oldest expected one
  always @(negedge clk) begin
    if (!rst && log_valid) begin
      if (sb.size() == 0) begin
        checks++;
        $display("FAIL mon_unexpected: got record {%0d,%0h} expected none", log_type, log_addr);
      end else begin
        chk("mon_type", log_type, sb[0].t);
        chk("mon_addr", log_addr, sb[0].a);
        if (log_ready) void'(sb.pop_front());
      end
    end
  end

  // One clock cycle: update the reference model from this cycle's inputs, then check
  task automatic step();
    bit ev, ue, irq_n;
    @(negedge clk); #1;
    ev = dec_valid && (single_err || double_err);
    ue = double_err;
    irq_n = m_irq || m_ue_pend || (ce_threshold != 0 && m_ce >= int'(ce_threshold));
    if (clear) begin
      m_ce = 0; m_ue = 0; m_occ = 0; m_ovf = 0; irq_n = 0;
      sb.delete();
    end else if (m_occ > 0 && log_ready) begin
      m_occ--;
    end
    if (ev) begin
      if (m_occ < DEPTH) begin
        m_occ++;
        sb.push_back('{ue, dec_addr});
      end else begin
        m_ovf = 1;
      end
      if (ue) m_ue = (m_ue < MAX) ? m_ue + 1 : MAX;
      else    m_ce = (m_ce < MAX) ? m_ce + 1 : MAX;
    end
    m_ue_pend = ev && ue;
    m_irq = irq_n;
    @(posedge clk); #1;
    chk("ce_count", ce_count, m_ce);
    chk("ue_count", ue_count, m_ue);
    chk("irq", irq, m_irq);
    chk("log_overflow", log_overflow, m_ovf);
    chk("log_valid", log_valid, m_occ > 0);
  endtask

  task automatic cyc(input bit dv, input bit se, input bit de, input logic [AW-1:0] a, input bit clr);
    dec_valid = dv; single_err = se; double_err = de; dec_addr = a; clear = clr;
    step();
    dec_valid = 0; single_err = 0; double_err = 0; clear = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, '0, 0);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_ce"}, ce_count, 0);
    chk({tag, "_ue"}, ue_count, 0);
    chk({tag, "_valid"}, log_valid, 0);
    chk({tag, "_type"}, log_type, 0);
    chk({tag, "_addr"}, log_addr, 0);
    chk({tag, "_ovf"}, log_overflow, 0);
    chk({tag, "_irq"}, irq, 0);
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 0;

    // Three CE beats held in the FIFO, threshold disabled
    cyc(1, 1, 0, 32'h100, 0);
    cyc(1, 1, 0, 32'h104, 0);
    cyc(1, 1, 0, 32'h108, 0);
    idle(2);
    chk("t1_ce", ce_count, 3);
    chk("t1_head", log_addr, 32'h100);
    chk("t1_irq", irq, 0);
    cyc(0, 0, 0, '0, 1);

    // CE threshold interrupt, then clear
    ce_threshold = 2;
    cyc(1, 1, 0, 32'h200, 0);
    cyc(1, 1, 0, 32'h204, 0);
    chk("t2_ce", ce_count, 2);
    chk("t2_irq_early", irq, 0);
    idle(1);
    chk("t2_irq", irq, 1);
    idle(2);
    cyc(0, 0, 0, '0, 1);
    check_all_zero("t2_clear");

    // Both flags set classifies as UE
    ce_threshold = 0;
    cyc(1, 1, 1, 32'hDEAD0000, 0);
    chk("t3_irq_early", irq, 0);
    idle(1);
    chk("t3_ue", ue_count, 1);
    chk("t3_type", log_type, 1);
    chk("t3_irq", irq, 1);
    cyc(0, 0, 0, '0, 1);

    // Overflow, then full FIFO with simultaneous push and pop
    for (int i = 1; i <= 6; i++) cyc(1, 1, 0, AW'(i), 0);
    chk("t4_ovf", log_overflow, 1);
    chk("t4_ce", ce_count, 6);
    log_ready = 1;
    cyc(1, 1, 0, 32'h7, 0);
    idle(6);
    chk("t4_drained", sb.size(), 0);
    log_ready = 0;
    cyc(0, 0, 0, '0, 1);

    // Counter saturation at 15
    log_ready = 1;
    for (int i = 0; i < 20; i++) cyc(1, 1, 0, AW'(i), 0);
    chk("t5_sat", ce_count, 15);
    idle(6);
    cyc(0, 0, 0, '0, 1);

    // Clear with a same-cycle CE and three records queued
    log_ready = 0;
    for (int i = 0; i < 3; i++) cyc(1, 1, 0, AW'(32'h300 + i), 0);
    cyc(1, 1, 0, 32'hABC, 1);
    chk("t6_ce", ce_count, 1);
    chk("t6_head", log_addr, 32'hABC);
    chk("t6_ovf", log_overflow, 0);
    log_ready = 1;
    idle(2);

    // Randomized traffic with a mid-run asynchronous reset
    for (int n = 0; n < 1500; n++) begin
      if (n % 100 == 0) ce_threshold = CW'($urandom_range(0, 7));
      log_ready = 1'($urandom);
      if (n == 700) begin
        rst = 1;
        #2;
        check_all_zero("midreset");
        model_reset();
        @(posedge clk); #1;
        rst = 0;
      end
      cyc(1'($urandom), 1'($urandom), ($urandom % 4) == 0, $urandom, ($urandom % 60) == 0);
    end

    log_ready = 1;
    idle(DEPTH + 2);
    chk("final_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
